// File: rtl/serpent_dec_ctrl.sv
// Iterative round sequencer for the Serpent decryption core: loads one ciphertext
// block, steps the external inverse-round datapath NUM_ROUNDS-1 down to 0, hands off.
module serpent_dec_ctrl #(
    parameter int unsigned NUM_ROUNDS = 32
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_clear,
    input  logic         i_key_ready,
    input  logic         i_in_valid,
    output logic         o_in_ready,
    input  logic [127:0] i_in_data,
    output logic [5:0]   o_round,
    output logic [5:0]   o_key_idx,
    output logic [127:0] o_round_data,
    input  logic [127:0] i_round_data,
    output logic         o_busy,
    output logic         o_out_valid,
    input  logic         i_out_ready,
    output logic [127:0] o_out_data
);

    localparam logic [5:0] LAST_ROUND = 6'(NUM_ROUNDS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_q;
    state_t        state_d;
    logic [5:0]    round_q;
    logic [127:0]  data_q;
    logic          accept;

    assign accept = i_in_valid & o_in_ready;

    // NOTE: registers are written with non-blocking assignments so every flop
    // samples the pre-edge values of its neighbours, matching real hardware.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every output of a combinational block gets a default before any
    // branch; a path that leaves it unassigned would infer a latch.
    always_comb begin
        state_d = state_q;
        if (i_clear) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: if (accept) state_d = RUN;
                RUN:  if (round_q == '0) state_d = DONE;
                DONE: if (i_out_ready) state_d = accept ? RUN : IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        o_busy      = (state_q == RUN);
        o_out_valid = (state_q == DONE);
        o_in_ready  = i_key_ready & ~i_clear &
                      ((state_q == IDLE) | ((state_q == DONE) & i_out_ready));
    end

    // Round counter and block state; the block is kept across an abort so the
    // datapath input stays quiet until the next load.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            round_q <= '0;
            data_q  <= '0;
        end else if (i_clear) begin
            round_q <= '0;
        end else begin
            unique case (state_q)
                IDLE, DONE: begin
                    if (accept) begin
                        round_q <= LAST_ROUND;
                        data_q  <= i_in_data;
                    end
                end
                RUN: begin
                    data_q <= i_round_data;
                    if (round_q != '0) round_q <= round_q - 6'd1;
                end
                default: round_q <= '0;
            endcase
        end
    end

    assign o_round      = round_q;
    assign o_key_idx    = round_q;
    assign o_round_data = data_q;
    assign o_out_data   = data_q;

endmodule

// File: tb/tb_serpent_dec_ctrl.sv
// Self-checking bench for serpent_dec_ctrl: per-cycle comparison against a
// transaction-level model, directed scenarios, random traffic, NUM_ROUNDS=4 instance.
module tb_serpent_dec_ctrl;

    localparam int N = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         clear = 1'b0;
    logic         key_ready = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [127:0] in_data = '0;
    logic [5:0]   round;
    logic [5:0]   key_idx;
    logic [127:0] round_data;
    logic [127:0] dp_data;
    logic         busy;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [127:0] out_data;

    logic         p_key_ready = 1'b0;
    logic         p_in_valid = 1'b0;
    logic         p_in_ready;
    logic [127:0] p_in_data = '0;
    logic [5:0]   p_round;
    logic [5:0]   p_key_idx;
    logic [127:0] p_round_data;
    logic [127:0] p_dp_data;
    logic         p_busy;
    logic         p_out_valid;
    logic         p_out_ready = 1'b0;
    logic [127:0] p_out_data;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // Bench datapath: next = state + round + 1
    assign dp_data   = round_data + 128'(round) + 128'd1;
    assign p_dp_data = p_round_data + 128'(p_round) + 128'd1;

    serpent_dec_ctrl #(.NUM_ROUNDS(N)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_clear(clear), .i_key_ready(key_ready),
        .i_in_valid(in_valid), .o_in_ready(in_ready), .i_in_data(in_data),
        .o_round(round), .o_key_idx(key_idx), .o_round_data(round_data),
        .i_round_data(dp_data), .o_busy(busy), .o_out_valid(out_valid),
        .i_out_ready(out_ready), .o_out_data(out_data)
    );

    serpent_dec_ctrl #(.NUM_ROUNDS(4)) dut4 (
        .i_clk(clk), .i_rst_n(rst_n), .i_clear(1'b0), .i_key_ready(p_key_ready),
        .i_in_valid(p_in_valid), .o_in_ready(p_in_ready), .i_in_data(p_in_data),
        .o_round(p_round), .o_key_idx(p_key_idx), .o_round_data(p_round_data),
        .i_round_data(p_dp_data), .o_busy(p_busy), .o_out_valid(p_out_valid),
        .i_out_ready(p_out_ready), .o_out_data(p_out_data)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction model: a block loaded with value B, after k round edges, holds
    // B + sum of (N - j) for j = 0..k-1; it is done after N edges.
    typedef enum {M_IDLE, M_RUN, M_DONE} phase_t;
    phase_t       m_phase;
    int           m_k;
    logic [127:0] m_base;
    logic [127:0] m_data;

    function automatic logic [127:0] partial_sum(input int k);
        return 128'(k * N - (k * (k - 1)) / 2);
    endfunction

    function automatic logic model_in_ready();
        return key_ready && !clear &&
               (m_phase == M_IDLE || (m_phase == M_DONE && out_ready));
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase <= M_IDLE;
            m_k     <= 0;
            m_base  <= '0;
            m_data  <= '0;
        end else begin
            automatic logic   acc = in_valid && model_in_ready();
            automatic phase_t ph  = m_phase;
            automatic int     k   = m_k;
            automatic logic [127:0] base = m_base;
            automatic logic [127:0] dat  = m_data;
            if (clear) begin
                ph = M_IDLE;
            end else if ((ph == M_IDLE || (ph == M_DONE && out_ready)) && acc) begin
                ph = M_RUN; k = 0; base = in_data; dat = in_data;
            end else if (ph == M_DONE && out_ready) begin
                ph = M_IDLE;
            end else if (ph == M_RUN) begin
                k++;
                dat = base + partial_sum(k);
                if (k == N) ph = M_DONE;
            end
            m_phase <= ph;
            m_k     <= k;
            m_base  <= base;
            m_data  <= dat;
        end
    end

    // Compare process: outputs against the model away from the active edge
    always @(negedge clk) begin
        if (rst_n) begin
            check("busy", 128'(busy), 128'(m_phase == M_RUN));
            check("out_valid", 128'(out_valid), 128'(m_phase == M_DONE));
            check("round", 128'(round), (m_phase == M_RUN) ? 128'(N - 1 - m_k) : 128'd0);
            check("key_idx", 128'(key_idx), (m_phase == M_RUN) ? 128'(N - 1 - m_k) : 128'd0);
            check("round_data", round_data, m_data);
            check("out_data", out_data, m_data);
            check("in_ready", 128'(in_ready), 128'(model_in_ready()));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Waits for out_valid, returns cycles taken and how many cycles busy was high
    task automatic wait_valid(input string name, input int bound, output int cycles, output int busy_cnt);
        cycles = 0;
        busy_cnt = 0;
        while (!out_valid && cycles < bound) begin
            if (busy) busy_cnt++;
            step();
            cycles++;
        end
        if (!out_valid) check({name, "_timeout"}, 128'(out_valid), 128'd1);
    endtask

    initial begin
        int cyc;
        int bcnt;
        int rounds_seen[$];
        logic [127:0] x;

        // Reset state
        #12;
        check("rst_busy", 128'(busy), 128'd0);
        check("rst_valid", 128'(out_valid), 128'd0);
        check("rst_round", 128'(round), 128'd0);
        check("rst_data", round_data, 128'd0);
        key_ready = 1'b1;
        #1;
        check("rst_in_ready_follows_key", 128'(in_ready), 128'd1);
        key_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Key gating
        in_valid = 1'b1;
        in_data  = '0;
        for (int i = 0; i < 3; i++) begin
            check("gate_in_ready", 128'(in_ready), 128'd0);
            step();
            check("gate_busy", 128'(busy), 128'd0);
        end
        key_ready = 1'b1;
        #1;
        check("gate_in_ready_raised", 128'(in_ready), 128'd1);
        step();
        in_valid = 1'b0;

        // Basic block: rounds 31..0, 32 cycles, result 528
        cyc = 0;
        bcnt = 0;
        rounds_seen.delete();
        while (!out_valid && cyc < 100) begin
            rounds_seen.push_back(int'(round));
            if (busy) bcnt++;
            step();
            cyc++;
        end
        check("basic_latency", 128'(cyc), 128'd32);
        check("basic_busy_cycles", 128'(bcnt), 128'd32);
        check("basic_result", out_data, 128'd528);
        check("basic_round_count", 128'(rounds_seen.size()), 128'd32);
        for (int i = 0; i < rounds_seen.size(); i++)
            check("basic_round_seq", 128'(rounds_seen[i]), 128'(31 - i));

        // Backpressure
        for (int i = 0; i < 10; i++) begin
            step();
            check("bp_hold_data", out_data, 128'd528);
            check("bp_hold_valid", 128'(out_valid), 128'd1);
        end

        // Back-to-back handoff
        in_valid  = 1'b1;
        in_data   = 128'd100;
        out_ready = 1'b1;
        #1;
        check("b2b_in_ready", 128'(in_ready), 128'd1);
        step();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("b2b_busy", 128'(busy), 128'd1);
        check("b2b_round", 128'(round), 128'd31);
        check("b2b_loaded", round_data, 128'd100);
        wait_valid("b2b", 100, cyc, bcnt);
        check("b2b_latency", 128'(cyc), 128'd32);
        check("b2b_result", out_data, 128'd628);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("b2b_drained", 128'(out_valid), 128'd0);

        // Abort at round 15
        in_valid = 1'b1;
        in_data  = '0;
        step();
        in_valid = 1'b0;
        cyc = 0;
        while (round != 6'd15 && cyc < 100) begin
            step();
            cyc++;
        end
        check("abort_reach_15", 128'(round), 128'd15);
        clear = 1'b1;
        step();
        clear = 1'b0;
        check("abort_busy", 128'(busy), 128'd0);
        check("abort_round", 128'(round), 128'd0);
        check("abort_data_held", round_data, 128'd392);
        bcnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (out_valid) bcnt++;
            step();
        end
        check("abort_no_valid", 128'(bcnt), 128'd0);
        clear = 1'b1;
        #1;
        check("clear_blocks_ready", 128'(in_ready), 128'd0);
        clear = 1'b0;
        x = rnd128();
        in_valid = 1'b1;
        in_data  = x;
        step();
        in_valid = 1'b0;
        wait_valid("after_abort", 100, cyc, bcnt);
        check("after_abort_result", out_data, x + 128'd528);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;

        // Async reset mid-RUN
        in_valid = 1'b1;
        in_data  = rnd128();
        step();
        in_valid = 1'b0;
        repeat (10) step();
        #1;
        rst_n = 1'b0;
        #1;
        check("arst_busy", 128'(busy), 128'd0);
        check("arst_valid", 128'(out_valid), 128'd0);
        check("arst_round", 128'(round), 128'd0);
        check("arst_key_idx", 128'(key_idx), 128'd0);
        check("arst_data", round_data, 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Random traffic against the model
        for (int i = 0; i < 1500; i++) begin
            key_ready = ($urandom_range(0, 9) != 0);
            in_valid  = $urandom_range(0, 1);
            in_data   = rnd128();
            out_ready = ($urandom_range(0, 2) != 0);
            clear     = ($urandom_range(0, 59) == 0);
            step();
        end
        clear = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (40) step();
        out_ready = 1'b0;

        // NUM_ROUNDS = 4 instance
        p_key_ready = 1'b1;
        p_in_valid  = 1'b1;
        p_in_data   = '0;
        step();
        p_in_valid = 1'b0;
        cyc = 0;
        bcnt = 0;
        rounds_seen.delete();
        while (!p_out_valid && cyc < 20) begin
            rounds_seen.push_back(int'(p_round));
            if (p_busy) bcnt++;
            step();
            cyc++;
        end
        check("p4_latency", 128'(cyc), 128'd4);
        check("p4_busy_cycles", 128'(bcnt), 128'd4);
        check("p4_result", p_out_data, 128'd10);
        check("p4_round_count", 128'(rounds_seen.size()), 128'd4);
        for (int i = 0; i < rounds_seen.size(); i++)
            check("p4_round_seq", 128'(rounds_seen[i]), 128'(3 - i));
        p_out_ready = 1'b1;
        step();
        check("p4_drained", 128'(p_out_valid), 128'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
